// File: rtl/audio_avg_filter.sv
// Moving-average low-pass filter for 10-bit unsigned ADC samples; signed result on a valid/ready port.
// Optional DC-bias removal enabled by defining AUDIO_AVG_DC_BLOCK_EN.
module audio_avg_filter #(
    parameter int unsigned LOG2_TAPS = 3,
    parameter int unsigned DC_SHIFT  = 8
) (
    input  logic       CLK50,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [9:0] adc_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [9:0] dout,
    output logic       primed,
    output logic       overrun
);

    localparam int unsigned TAPS   = 1 << LOG2_TAPS;
    localparam int unsigned SUM_W  = 10 + LOG2_TAPS;
    localparam int unsigned FILL_W = LOG2_TAPS + 1;

    if (LOG2_TAPS < 1 || LOG2_TAPS > 5 || DC_SHIFT < 1 || DC_SHIFT > 16) begin : g_bad_param
        $error("audio_avg_filter: LOG2_TAPS must be 1..5 and DC_SHIFT 1..16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [9:0]         r_x;
    logic signed [9:0]         r_buf [TAPS];
    logic [LOG2_TAPS-1:0]      r_wptr;
    logic signed [SUM_W-1:0]   r_sum;
    logic [FILL_W-1:0]         r_fill;

    logic signed [9:0]         w_x;
    logic signed [SUM_W-1:0]   w_sum_next;
    logic signed [9:0]         w_avg;
    logic [9:0]                w_result;
    logic                      w_fill_full;

    // Offset binary to two's complement: subtracting midscale is just an MSB flip.
    assign w_x         = {~adc_in[9], adc_in[8:0]};
    assign w_sum_next  = r_sum + SUM_W'(r_x) - SUM_W'(r_buf[r_wptr]);
    assign w_avg       = 10'(r_sum >>> LOG2_TAPS);
    assign w_fill_full = (r_fill == FILL_W'(TAPS));

`ifdef AUDIO_AVG_DC_BLOCK_EN
    localparam int unsigned DC_W = 10 + DC_SHIFT;

    logic signed [DC_W-1:0]    r_dc_acc;
    logic signed [9:0]         r_dc_est;
    logic signed [9:0]         w_dc_est;
    logic signed [10:0]        w_diff;

    // The estimate used in CALC is held so OUT subtracts the same value the tracker saw.
    assign w_dc_est = 10'(r_dc_acc >>> DC_SHIFT);
    assign w_diff   = {w_avg[9], w_avg} - {r_dc_est[9], r_dc_est};

    always_comb begin
        w_result = w_diff[9:0];
        if (w_diff > 11'sd511) begin
            w_result = 10'h1FF;
        end else if (w_diff < -11'sd512) begin
            w_result = 10'h200;
        end
    end

    always_ff @(posedge CLK50) begin
        if (reset) begin
            r_dc_acc <= '0;
            r_dc_est <= '0;
        end else if (r_state == S_CALC) begin
            r_dc_acc <= r_dc_acc + DC_W'(r_x) - DC_W'(w_dc_est);
            r_dc_est <= w_dc_est;
        end
    end
`else
    assign w_result = w_avg;
`endif

    always_ff @(posedge CLK50) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_wptr    <= '0;
            r_sum     <= '0;
            r_fill    <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            primed    <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            // Consumption clears valid; an OUT write below takes precedence.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (sample_valid) begin
                        r_x     <= w_x;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_sum         <= w_sum_next;
                    r_buf[r_wptr] <= r_x;
                    r_wptr        <= r_wptr + LOG2_TAPS'(1);
                    if (!w_fill_full) begin
                        r_fill <= r_fill + FILL_W'(1);
                    end
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    dout      <= w_result;
                    out_valid <= 1'b1;
                    if (w_fill_full) begin
                        primed <= 1'b1;
                    end
                    if ((out_valid && !out_ready) || sample_valid) begin
                        overrun <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_avg_filter.sv
// Directed bench for audio_avg_filter with LOG2_TAPS=2, DC_SHIFT=4.
module tb_audio_avg_filter;

    logic       CLK50 = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [9:0] adc_in;
    logic       out_ready;
    logic       out_valid;
    logic [9:0] dout;
    logic       primed;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] first_dout;

    audio_avg_filter #(
        .LOG2_TAPS(2),
        .DC_SHIFT (4)
    ) dut (
        .CLK50       (CLK50),
        .reset       (reset),
        .sample_valid(sample_valid),
        .adc_in      (adc_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .dout        (dout),
        .primed      (primed),
        .overrun     (overrun)
    );

    always #10 CLK50 = ~CLK50;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK50);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    // Strobe one sample and require the result exactly three cycles later.
    task automatic send_check(input string tag, input logic [9:0] v,
                              input logic [9:0] exp_dout, input logic exp_primed);
        sample_valid = 1'b1;
        adc_in       = v;
        tick(1);
        sample_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick(1);
        check({tag, "_lat2"}, 32'(out_valid), 32'd0);
        tick(1);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_dout"}, 32'(dout), 32'(exp_dout));
        check({tag, "_primed"}, 32'(primed), 32'(exp_primed));
    endtask

    task automatic send(input logic [9:0] v, input int gap);
        sample_valid = 1'b1;
        adc_in       = v;
        tick(1);
        sample_valid = 1'b0;
        tick(gap);
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        adc_in       = '0;
        out_ready    = 1'b0;
        tick(3);
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_dout",    32'(dout),      32'd0);
        check("rst_primed",  32'(primed),    32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);

        sample_valid = 1'b1;
        adc_in       = 10'd612;
        tick(2);
        sample_valid = 1'b0;
        tick(4);
        check("rst_hold_valid",   32'(out_valid), 32'd0);
        check("rst_hold_dout",    32'(dout),      32'd0);
        check("rst_hold_overrun", 32'(overrun),   32'd0);

        // Ramp up with +100 then down with -100; window of four.
        reset     = 1'b0;
        out_ready = 1'b1;
        tick(2);
        send_check("up1", 10'd612, 10'd25,  1'b0); tick(7);
        send_check("up2", 10'd612, 10'd50,  1'b0); tick(7);
        send_check("up3", 10'd612, 10'd75,  1'b0); tick(7);
        send_check("up4", 10'd612, 10'd100, 1'b1); tick(7);
        send_check("dn1", 10'd412, 10'd50,  1'b1); tick(7);
        send_check("dn2", 10'd412, 10'd0,   1'b1); tick(7);
        send_check("dn3", 10'd412, 10'h3CE, 1'b1); tick(7);
        send_check("dn4", 10'd412, 10'h39C, 1'b1); tick(2);
        check("ramp_overrun", 32'(overrun), 32'd0);

        // Output stalled: second result overwrites the first.
        do_reset();
        out_ready = 1'b0;
        tick(1);
        send(10'd612, 5);
        send(10'd612, 5);
        check("stall_valid",   32'(out_valid), 32'd1);
        check("stall_overrun", 32'(overrun),   32'd1);
        check("stall_dout",    32'(dout),      32'd50);
        check("stall_primed",  32'(primed),    32'd0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(1);
        check("stall_drain_valid", 32'(out_valid), 32'd0);
        tick(2);
        check("stall_dout_hold", 32'(dout), 32'd50);

        // Back-to-back strobes: second one dropped.
        do_reset();
        out_ready = 1'b1;
        tick(1);
        sample_valid = 1'b1;
        adc_in       = 10'd612;
        tick(1);
        adc_in       = 10'd1023;
        tick(1);
        sample_valid = 1'b0;
        tick(1);
        check("b2b_valid",   32'(out_valid), 32'd1);
        check("b2b_dout",    32'(dout),      32'd25);
        check("b2b_overrun", 32'(overrun),   32'd1);
        tick(5);
        check("b2b_no_second", 32'(out_valid), 32'd0);

        // Reset lands on the CALC edge: nothing may come out.
        do_reset();
        tick(1);
        sample_valid = 1'b1;
        adc_in       = 10'd900;
        tick(1);
        sample_valid = 1'b0;
        reset        = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("abort_valid", 32'(out_valid), 32'd0);
        end
        check("abort_dout",    32'(dout),    32'd0);
        check("abort_primed",  32'(primed),  32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);

        // Constant +200 input for 200 samples.
        do_reset();
        out_ready = 1'b1;
        tick(1);
        first_dout = '0;
        for (int i = 0; i < 200; i++) begin
            sample_valid = 1'b1;
            adc_in       = 10'd712;
            tick(1);
            sample_valid = 1'b0;
            tick(2);
            if (i == 0) first_dout = dout;
        end
        check("const_first", 32'(first_dout), 32'd50);
        check("const_valid", 32'(out_valid),  32'd1);
        check("const_overrun", 32'(overrun),  32'd0);
        check("const_primed",  32'(primed),   32'd1);
`ifdef AUDIO_AVG_DC_BLOCK_EN
        check("const_dc_removed", 32'(dout == 10'd0 || dout == 10'd1), 32'd1);
`else
        check("const_final", 32'(dout), 32'd200);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
